// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter
//   Round-robin arbiter/sequencer sharing one sequential multiplier among
//   NUM_REQ requesters. One operation in flight: grant + operand capture,
//   Start pulse, track Ready low (accepted) then high (done), return the
//   product with requester id on a valid/ready channel. A watchdog turns a
//   hung multiplier into an error response.
// Ports
//   clock, reset_b         : clock (rising edge), async active-low reset
//   req/req_a/req_b        : per-requester level request and operand slices
//   gnt                    : one-hot single-cycle grant pulse
//   mul_start              : Start pulse to the multiplier
//   mul_multiplicand/mul_multiplier : registered operands to the multiplier
//   mul_ready/mul_product  : multiplier Ready and Product
//   rsp_valid/rsp_ready    : response handshake
//   rsp_id/rsp_product/rsp_err : response payload (product 0 on error)
module mul_share_arbiter #(
  parameter int DP_WIDTH = 4,
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2,
  parameter int TIMEOUT  = 16
) (
  input  logic                         clock,
  input  logic                         reset_b,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*DP_WIDTH-1:0]  req_a,
  input  logic [NUM_REQ*DP_WIDTH-1:0]  req_b,
  output logic [NUM_REQ-1:0]           gnt,
  output logic                         mul_start,
  output logic [DP_WIDTH-1:0]          mul_multiplicand,
  output logic [DP_WIDTH-1:0]          mul_multiplier,
  input  logic                         mul_ready,
  input  logic [2*DP_WIDTH-1:0]        mul_product,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [ID_WIDTH-1:0]          rsp_id,
  output logic [2*DP_WIDTH-1:0]        rsp_product,
  output logic                         rsp_err
);

  localparam int PW  = 2*DP_WIDTH;
  localparam int WDW = $clog2(TIMEOUT+1);

  typedef enum logic [2:0] {IDLE, START, WAIT_LOW, BUSY, RESP} state_t;

  state_t                           state, state_n;
  logic [ID_WIDTH-1:0]              last, last_n;
  logic [ID_WIDTH-1:0]              cur_id, cur_id_n;
  logic [WDW-1:0]                   wd, wd_n;
  logic [NUM_REQ-1:0]               gnt_n;
  logic                             mul_start_n;
  logic [DP_WIDTH-1:0]              mcand_n, mplier_n;
  logic                             rsp_valid_n, rsp_err_n;
  logic [ID_WIDTH-1:0]              rsp_id_n;
  logic [PW-1:0]                    rsp_product_n;

  // Operand slices viewed as packed per-requester arrays.
  logic [NUM_REQ-1:0][DP_WIDTH-1:0] a_vec, b_vec;
  assign a_vec = req_a;
  assign b_vec = req_b;

  // Round-robin search: first set req bit starting at last+1, wrapping.
  logic                found;
  logic [ID_WIDTH-1:0] win;
  logic [ID_WIDTH-1:0] cand;
  logic [NUM_REQ-1:0]  req_sh;
  int                  idx;

  always_comb begin
    found  = 1'b0;
    win    = '0;
    cand   = '0;
    req_sh = '0;
    idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(last) + 1 + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand   = idx[ID_WIDTH-1:0];
      req_sh = req >> cand;
      if (!found && req_sh[0]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_n       = state;
    last_n        = last;
    cur_id_n      = cur_id;
    wd_n          = wd;
    gnt_n         = '0;
    mul_start_n   = 1'b0;
    mcand_n       = mul_multiplicand;
    mplier_n      = mul_multiplier;
    rsp_valid_n   = rsp_valid;
    rsp_err_n     = rsp_err;
    rsp_id_n      = rsp_id;
    rsp_product_n = rsp_product;
    case (state)
      IDLE: begin
        // A busy multiplier (Ready low) blocks arbitration entirely.
        if (mul_ready && found) begin
          gnt_n       = {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
          mul_start_n = 1'b1;
          mcand_n     = a_vec[win];
          mplier_n    = b_vec[win];
          cur_id_n    = win;
          wd_n        = '0;
          state_n     = START;
        end
      end
      START: state_n = WAIT_LOW;
      WAIT_LOW: begin
        // Watchdog has priority here: a multiplier that never drops Ready
        // never accepted Start.
        wd_n = wd + WDW'(1);
        if (wd_n == WDW'(TIMEOUT)) begin
          rsp_valid_n   = 1'b1;
          rsp_err_n     = 1'b1;
          rsp_product_n = '0;
          rsp_id_n      = cur_id;
          state_n       = RESP;
        end else if (!mul_ready) begin
          state_n = BUSY;
        end
      end
      BUSY: begin
        // A completion on the same edge as the timeout wins.
        wd_n = wd + WDW'(1);
        if (mul_ready) begin
          rsp_valid_n   = 1'b1;
          rsp_err_n     = 1'b0;
          rsp_product_n = mul_product;
          rsp_id_n      = cur_id;
          state_n       = RESP;
        end else if (wd_n == WDW'(TIMEOUT)) begin
          rsp_valid_n   = 1'b1;
          rsp_err_n     = 1'b1;
          rsp_product_n = '0;
          rsp_id_n      = cur_id;
          state_n       = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_n = 1'b0;
          last_n      = cur_id;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state            <= IDLE;
      last             <= ID_WIDTH'(NUM_REQ-1);
      cur_id           <= '0;
      wd               <= '0;
      gnt              <= '0;
      mul_start        <= 1'b0;
      mul_multiplicand <= '0;
      mul_multiplier   <= '0;
      rsp_valid        <= 1'b0;
      rsp_err          <= 1'b0;
      rsp_id           <= '0;
      rsp_product      <= '0;
    end else begin
      state            <= state_n;
      last             <= last_n;
      cur_id           <= cur_id_n;
      wd               <= wd_n;
      gnt              <= gnt_n;
      mul_start        <= mul_start_n;
      mul_multiplicand <= mcand_n;
      mul_multiplier   <= mplier_n;
      rsp_valid        <= rsp_valid_n;
      rsp_err          <= rsp_err_n;
      rsp_id           <= rsp_id_n;
      rsp_product      <= rsp_product_n;
    end
  end

endmodule

// File: tb/tb_mul_share_arbiter.sv
module tb_mul_share_arbiter;

  localparam int DPW  = 4;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int TMO  = 16;
  localparam int MUL_CYC = 5;

  logic                 clock, reset_b;
  logic [NREQ-1:0]      req;
  logic [NREQ*DPW-1:0]  req_a, req_b;
  logic [NREQ-1:0]      gnt;
  logic                 mul_start;
  logic [DPW-1:0]       mul_multiplicand, mul_multiplier;
  logic                 mul_ready;
  logic [2*DPW-1:0]     mul_product;
  logic                 rsp_valid, rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [2*DPW-1:0]     rsp_product;
  logic                 rsp_err;

  int errors = 0;
  int checks = 0;
  bit hang   = 0;

  mul_share_arbiter #(.DP_WIDTH(DPW), .NUM_REQ(NREQ), .ID_WIDTH(IDW), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset_b(reset_b), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .mul_start(mul_start), .mul_multiplicand(mul_multiplicand),
    .mul_multiplier(mul_multiplier), .mul_ready(mul_ready), .mul_product(mul_product),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_product(rsp_product), .rsp_err(rsp_err)
  );

  initial clock = 0;
  always #5 clock = ~clock;

  // Sequential multiplier model: Start accepted while Ready, Ready low for
  // MUL_CYC cycles, then product and Ready together. hang ignores Start.
  logic [DPW-1:0] pa, pb;
  int             m_cnt;
  always @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      mul_ready   <= 1'b1;
      mul_product <= '0;
      m_cnt       <= 0;
      pa          <= '0;
      pb          <= '0;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        mul_ready   <= 1'b1;
        mul_product <= {4'b0, pa} * {4'b0, pb};
      end
    end else if (mul_start && mul_ready && !hang) begin
      mul_ready <= 1'b0;
      pa        <= mul_multiplicand;
      pb        <= mul_multiplier;
      m_cnt     <= MUL_CYC;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_gnt(input logic [NREQ-1:0] exp);
    int n = 0;
    do begin @(negedge clock); n++; end while (gnt == 0 && n < 60);
    chk("gnt", 32'(gnt), 32'(exp));
    chk("mul_start_with_gnt", 32'(mul_start), 1);
  endtask

  task automatic wait_rsp(input logic [IDW-1:0] id, input logic [7:0] prod, input logic err);
    int n = 0;
    while (!rsp_valid && n < 80) begin @(negedge clock); n++; end
    chk("rsp_valid", 32'(rsp_valid), 1);
    chk("rsp_id", 32'(rsp_id), 32'(id));
    chk("rsp_product", 32'(rsp_product), 32'(prod));
    chk("rsp_err", 32'(rsp_err), 32'(err));
  endtask

  task automatic do_reset();
    reset_b = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_b = 1;
  endtask

  // Full operation with rsp_ready=1: grant, single-cycle Start, response,
  // then the response drops right after the accepting edge.
  task automatic run_op(input logic [3:0] r, input logic [15:0] a, input logic [15:0] b,
                        input logic [IDW-1:0] id, input logic [7:0] prod);
    req = r; req_a = a; req_b = b;
    wait_gnt(4'b0001 << id);
    req = '0;
    @(negedge clock);
    chk("gnt_one_cycle", 32'({gnt, mul_start}), 0);
    wait_rsp(id, prod, 1'b0);
    @(negedge clock);
    chk("rsp_valid_drop", 32'(rsp_valid), 0);
  endtask

  typedef struct {
    bit             rst;
    logic [3:0]     rq;
    logic [15:0]    a;
    logic [15:0]    b;
    logic [IDW-1:0] id;
    logic [7:0]     prod;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    vecs[0] = '{0, 4'b0001, 16'h0008, 16'h0009, 2'd0, 8'd72};
    vecs[1] = '{1, 4'b1111, 16'h4321, 16'h3333, 2'd0, 8'd3};
    vecs[2] = '{0, 4'b1111, 16'h4321, 16'h3333, 2'd1, 8'd6};
    vecs[3] = '{0, 4'b1111, 16'h4321, 16'h3333, 2'd2, 8'd9};
    vecs[4] = '{0, 4'b1111, 16'h4321, 16'h3333, 2'd3, 8'd12};
    vecs[5] = '{0, 4'b0101, 16'h4321, 16'h3333, 2'd0, 8'd3};
    vecs[6] = '{0, 4'b0101, 16'h4321, 16'h3333, 2'd2, 8'd9};
    vecs[7] = '{0, 4'b0010, 16'h00F0, 16'h00F0, 2'd1, 8'd225};
    vecs[8] = '{0, 4'b1000, 16'h0000, 16'hA000, 2'd3, 8'd0};

    reset_b = 0; req = '0; req_a = '0; req_b = '0; rsp_ready = 1;
    #3;
    chk("reset_outputs", 32'({gnt, mul_start, mul_multiplicand, mul_multiplier,
                              rsp_valid, rsp_id, rsp_product, rsp_err}), 0);
    @(negedge clock);
    reset_b = 1;
    @(negedge clock);
    chk("idle_no_req_gnt", 32'(gnt), 0);

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].rst) do_reset();
      run_op(vecs[i].rq, vecs[i].a, vecs[i].b, vecs[i].id, vecs[i].prod);
    end

    // Backpressure: response held, pending request not granted.
    rsp_ready = 0;
    req = 4'b0100; req_a = 16'h0500; req_b = 16'h0500;
    wait_gnt(4'b0100);
    req = '0;
    wait_rsp(2'd2, 8'd25, 1'b0);
    req = 4'b0010; req_a = 16'h0060; req_b = 16'h0070;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("bp_hold", 32'({rsp_valid, rsp_id, rsp_product, gnt}), 32'({1'b1, 2'd2, 8'd25, 4'b0000}));
    end
    rsp_ready = 1;
    @(negedge clock);
    chk("bp_accept", 32'({rsp_valid, gnt}), 0);
    @(negedge clock);
    chk("bp_next_gnt", 32'(gnt), 32'(4'b0010));
    req = '0;
    wait_rsp(2'd1, 8'd42, 1'b0);
    @(negedge clock);

    // Watchdog: multiplier ignores Start with Ready stuck high.
    hang = 1;
    req = 4'b0001; req_a = 16'h0002; req_b = 16'h0003;
    wait_gnt(4'b0001);
    req = '0;
    n = 0;
    do begin @(negedge clock); n++; end while (!rsp_valid && n < 60);
    chk("wd_latency", 32'(n), TMO + 1);
    wait_rsp(2'd0, 8'd0, 1'b1);
    @(negedge clock);
    chk("wd_rsp_drop", 32'(rsp_valid), 0);
    hang = 0;
    run_op(4'b0010, 16'h0050, 16'h0060, 2'd1, 8'd30);

    // Reset in the middle of BUSY.
    req = 4'b1000; req_a = 16'h9000; req_b = 16'h9000;
    wait_gnt(4'b1000);
    req = '0;
    n = 0;
    do begin @(negedge clock); n++; end while (mul_ready && n < 20);
    @(negedge clock);
    @(posedge clock);
    #2 reset_b = 0;
    #1;
    chk("midbusy_reset_outputs", 32'({gnt, mul_start, mul_multiplicand, mul_multiplier,
                                      rsp_valid, rsp_id, rsp_product, rsp_err}), 0);
    @(negedge clock);
    reset_b = 1;
    run_op(4'b0011, 16'h0077, 16'h0077, 2'd0, 8'd49);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
